// File: rtl/flash_audio_pkg.sv
// Shared types and helpers for the flash audio sample sequencer: FSM state
// encoding, sample/word widths and the wrap-around address step.
package flash_audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int FLASH_WORD_W = 32;
  localparam int ADDR_MAX_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    SETTLE,
    WAIT,
    FIRST,
    SECOND
  } seq_state_t;

  // Callers zero-extend narrower addresses to ADDR_MAX_W and truncate the result.
  function automatic logic [ADDR_MAX_W-1:0] next_addr(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic                  dir,
    input logic [ADDR_MAX_W-1:0] start_addr,
    input logic [ADDR_MAX_W-1:0] end_addr
  );
    logic [ADDR_MAX_W-1:0] nxt;
    if (!dir) begin
      nxt = (addr == end_addr) ? start_addr : addr + 32'd1;
    end else begin
      nxt = (addr == start_addr) ? end_addr : addr - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/addr_stepper.sv
// Flash word-address register: loads the song start for the current direction,
// or steps one word forward/backward with wrap between START_ADDR and END_ADDR.
module addr_stepper
  import flash_audio_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 'h7FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= START_ADDR;
    end else if (load) begin
      addr <= dir ? END_ADDR : START_ADDR;
    end else if (step) begin
      addr <= ADDR_W'(next_addr(ADDR_MAX_W'(addr), dir,
                                ADDR_MAX_W'(START_ADDR), ADDR_MAX_W'(END_ADDR)));
    end
  end

endmodule

// File: rtl/flash_sample_sequencer.sv
// Audio-rate sequencer in front of flash_reader: strobes a word address, waits
// for the read to settle, then plays the word's two signed 16-bit halves on ticks.
module flash_sample_sequencer
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 'h7FFFF,
  parameter int                SETTLE_CYC = 3
) (
  input  logic                    sample_clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    play,
  input  logic                    direction,
  input  logic                    restart,
  input  logic                    valid_read_flag,
  input  logic [FLASH_WORD_W-1:0] flash_mem_readdata,
  output logic [ADDR_W-1:0]       flash_mem_address,
  output logic                    address_clk,
  output logic [SAMPLE_W-1:0]     audio_sample,
  output logic                    sample_valid,
  output logic                    underrun
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  seq_state_t state, state_next;
  logic [7:0] cnt;
  logic [FLASH_WORD_W-1:0] word;
  logic word_dir;
  logic take_word, under, step, load;
  logic run_tick;
  logic signed [SAMPLE_W-1:0] sample_p0;
  logic vld_p0;

  assign run_tick = sample_tick & play;

  // Restart drops the strobe in the same cycle so a re-strobe always shows a fresh edge.
  assign address_clk = (state == STROBE) && !restart;

  addr_stepper #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR),
    .END_ADDR  (END_ADDR)
  ) u_addr_stepper (
    .clk (sample_clk),
    .rst (reset),
    .load(load),
    .step(step),
    .dir (direction),
    .addr(flash_mem_address)
  );

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (restart || (state_next != state)) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    take_word  = 1'b0;
    under      = 1'b0;
    step       = 1'b0;
    load       = 1'b0;
    vld_p0     = 1'b0;
    sample_p0  = word[15:0];
    if (restart) begin
      load       = 1'b1;
      state_next = play ? STROBE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play) state_next = STROBE;
        end
        STROBE: begin
          under = run_tick;
          if (cnt == 8'd1) state_next = SETTLE;
        end
        // valid_read_flag may still be high from the previous read here.
        SETTLE: begin
          under = run_tick;
          if (cnt == SETTLE_LAST) state_next = WAIT;
        end
        WAIT: begin
          under = run_tick;
          if (valid_read_flag) begin
            take_word  = 1'b1;
            state_next = FIRST;
          end
        end
        FIRST: begin
          if (run_tick) begin
            vld_p0     = 1'b1;
            sample_p0  = word_dir ? word[31:16] : word[15:0];
            state_next = SECOND;
          end
        end
        SECOND: begin
          if (run_tick) begin
            vld_p0     = 1'b1;
            sample_p0  = word_dir ? word[15:0] : word[31:16];
            step       = 1'b1;
            state_next = STROBE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Stage p0 -> output: one-cycle latency from tick to audio_sample/sample_valid.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      word         <= '0;
      word_dir     <= 1'b0;
      audio_sample <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (restart) begin
        word <= '0;
      end else if (take_word) begin
        word     <= flash_mem_readdata;
        word_dir <= direction;
      end
      if (vld_p0) audio_sample <= sample_p0;
      sample_valid <= vld_p0;
      underrun     <= under;
    end
  end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer with a small flash_reader model
// (configurable valid delay and stale-valid hold) and an 8-word song.
module tb_flash_sample_sequencer;

  localparam int ADDR_W = 23;

  logic              sample_clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic              play = 1'b0;
  logic              direction = 1'b0;
  logic              restart = 1'b0;
  logic              valid_read_flag = 1'b0;
  logic [31:0]       flash_mem_readdata = 32'h0;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              address_clk;
  logic [15:0]       audio_sample;
  logic              sample_valid;
  logic              underrun;

  flash_sample_sequencer #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(23'd0),
    .END_ADDR  (23'd7),
    .SETTLE_CYC(3)
  ) dut (
    .sample_clk        (sample_clk),
    .reset             (reset),
    .sample_tick       (sample_tick),
    .play              (play),
    .direction         (direction),
    .restart           (restart),
    .valid_read_flag   (valid_read_flag),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_address (flash_mem_address),
    .address_clk       (address_clk),
    .audio_sample      (audio_sample),
    .sample_valid      (sample_valid),
    .underrun          (underrun)
  );

  always #5 sample_clk = ~sample_clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [8];
  int flash_delay = 6;
  int stale_cyc = 1;
  int since = 0;
  logic ac_d = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;

  // Flash reader model: valid drops stale_cyc cycles after a strobe edge and
  // rises with the new word flash_delay cycles after it.
  always @(posedge sample_clk) begin
    ac_d <= address_clk;
    if (address_clk && !ac_d) begin
      since      <= 1;
      fetch_addr <= flash_mem_address;
    end else if (since != 0) begin
      if (since == stale_cyc) valid_read_flag <= 1'b0;
      if (since == flash_delay) begin
        valid_read_flag    <= 1'b1;
        flash_mem_readdata <= mem[fetch_addr[2:0]];
        since              <= 0;
      end else begin
        since <= since + 1;
      end
    end
  end

  int strobe_addr[$];
  int strobe_len[$];
  int hi_len = 0;
  int under_cnt = 0;
  int addr_unstable = 0;
  logic mon_prev = 1'b0;

  always @(negedge sample_clk) begin
    if (address_clk && !mon_prev) begin
      strobe_addr.push_back(int'(flash_mem_address));
      hi_len = 1;
    end else if (address_clk && mon_prev) begin
      hi_len++;
      if (int'(flash_mem_address) != strobe_addr[$]) addr_unstable++;
    end else if (!address_clk && mon_prev) begin
      strobe_len.push_back(hi_len);
    end
    if (underrun) under_cnt++;
    mon_prev = address_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  task automatic pulse_tick(output logic sv, output logic ur, output logic [15:0] smp);
    @(negedge sample_clk);
    sample_tick = 1'b1;
    @(negedge sample_clk);
    sample_tick = 1'b0;
    sv  = sample_valid;
    ur  = underrun;
    smp = audio_sample;
  endtask

  logic sv, ur;
  logic [15:0] smp;
  int under_before;

  initial begin
    mem[0] = 32'h1234_ABCD; mem[1] = 32'h2222_1111;
    mem[2] = 32'h4444_3333; mem[3] = 32'h6666_5555;
    mem[4] = 32'h8888_7777; mem[5] = 32'hAAAA_9999;
    mem[6] = 32'hCCCC_BBBB; mem[7] = 32'hEEEE_DDDD;

    idle(3);
    check("rst_addr", 32'(flash_mem_address), 32'd0);
    check("rst_addr_clk", 32'(address_clk), 32'd0);
    check("rst_sample", 32'(audio_sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    idle(2);
    play = 1'b1;

    // Forward playback through the whole song, including END_ADDR -> START_ADDR.
    for (int a = 0; a < 8; a++) begin
      idle(20);
      pulse_tick(sv, ur, smp);
      check("fwd_lo_valid", 32'(sv), 32'd1);
      check("fwd_lo", 32'(smp), 32'(mem[a][15:0]));
      idle(20);
      pulse_tick(sv, ur, smp);
      check("fwd_hi_valid", 32'(sv), 32'd1);
      check("fwd_hi", 32'(smp), 32'(mem[a][31:16]));
      check("fwd_addr", 32'(flash_mem_address), 32'((a + 1) % 8));
    end
    idle(5);
    check("strobe_count", 32'(strobe_addr.size()), 32'd9);
    check("strobe0_addr", 32'(strobe_addr[0]), 32'd0);
    check("strobe0_len", 32'(strobe_len[0]), 32'd2);
    check("strobe_wrap_addr", 32'(strobe_addr[strobe_addr.size() - 1]), 32'd0);
    check("addr_stable", 32'(addr_unstable), 32'd0);
    check("no_underrun_yet", 32'(under_cnt), 32'd0);

    // Direction flips mid-word: second half keeps the fetch-time order.
    idle(15);
    pulse_tick(sv, ur, smp);
    check("mid_lo", 32'(smp), 32'h0000_ABCD);
    direction = 1'b1;
    idle(20);
    pulse_tick(sv, ur, smp);
    check("mid_hi", 32'(smp), 32'h0000_1234);
    check("rev_wrap_addr", 32'(flash_mem_address), 32'd7);
    idle(20);
    pulse_tick(sv, ur, smp);
    check("rev_first_hi", 32'(smp), 32'h0000_EEEE);
    flash_delay = 40;
    stale_cyc   = 4;
    idle(20);
    pulse_tick(sv, ur, smp);
    check("rev_second_lo", 32'(smp), 32'h0000_DDDD);
    check("rev_addr", 32'(flash_mem_address), 32'd6);

    // Underrun while waiting on a slow read; stale valid must not be latched.
    idle(15);
    under_before = under_cnt;
    pulse_tick(sv, ur, smp);
    check("ur_pulse", 32'(ur), 32'd1);
    check("ur_no_valid", 32'(sv), 32'd0);
    check("ur_hold", 32'(smp), 32'h0000_DDDD);
    idle(2);
    check("ur_once", 32'(under_cnt - under_before), 32'd1);
    idle(40);
    pulse_tick(sv, ur, smp);
    check("after_ur_valid", 32'(sv), 32'd1);
    check("after_ur_hi", 32'(smp), 32'h0000_CCCC);
    flash_delay = 6;
    stale_cyc   = 1;
    idle(20);
    pulse_tick(sv, ur, smp);
    check("after_ur_lo", 32'(smp), 32'h0000_BBBB);
    check("rev_addr5", 32'(flash_mem_address), 32'd5);

    // Pause: ticks are ignored entirely.
    idle(20);
    play = 1'b0;
    under_before = under_cnt;
    for (int i = 0; i < 5; i++) begin
      idle(3);
      pulse_tick(sv, ur, smp);
      check("pause_no_valid", 32'(sv), 32'd0);
      check("pause_no_ur", 32'(ur), 32'd0);
    end
    check("pause_hold", 32'(smp), 32'h0000_BBBB);
    check("pause_ur_cnt", 32'(under_cnt - under_before), 32'd0);

    // Restart coinciding with a tick, forward direction, resuming play.
    direction = 1'b0;
    play      = 1'b1;
    @(negedge sample_clk);
    restart     = 1'b1;
    sample_tick = 1'b1;
    @(negedge sample_clk);
    restart     = 1'b0;
    sample_tick = 1'b0;
    check("rst_tick_no_valid", 32'(sample_valid), 32'd0);
    check("rst_tick_no_ur", 32'(underrun), 32'd0);
    check("restart_addr", 32'(flash_mem_address), 32'd0);
    idle(5);
    check("restart_strobe", 32'(strobe_addr[strobe_addr.size() - 1]), 32'd0);
    idle(15);
    pulse_tick(sv, ur, smp);
    check("restart_lo", 32'(smp), 32'h0000_ABCD);
    idle(20);
    pulse_tick(sv, ur, smp);
    check("restart_hi", 32'(smp), 32'h0000_1234);

    // Async reset mid-fetch in SETTLE, checked before any clock edge.
    for (int i = 0; i < 50 && !address_clk; i++) @(negedge sample_clk);
    check("pre_reset_strobe", 32'(address_clk), 32'd1);
    for (int i = 0; i < 50 && address_clk; i++) @(negedge sample_clk);
    check("pre_reset_settle", 32'(address_clk), 32'd0);
    check("pre_reset_addr", 32'(flash_mem_address), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_addr", 32'(flash_mem_address), 32'd0);
    check("async_addr_clk", 32'(address_clk), 32'd0);
    check("async_sample", 32'(audio_sample), 32'd0);
    check("async_valid", 32'(sample_valid), 32'd0);
    check("async_underrun", 32'(underrun), 32'd0);
    idle(3);
    check("held_reset_no_strobe", 32'(address_clk), 32'd0);
    reset = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
